// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and bubble counter
// Define PIPE_SKID_EN for a 2-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
  parameter int                LANE_W    = 32,
  parameter int                LANES     = 3,
  parameter logic [LANE_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANE_W*LANES-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANE_W*LANES-1:0]  out_data,
  output logic [CNT_W-1:0]         bubble_cnt
);

  localparam int DATA_W = LANE_W * LANES;
  localparam logic [DATA_W-1:0] NOP_DATA = {LANES{NOP_VALUE}};

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              accept;
  logic              consume;

  assign accept    = in_valid & in_ready;
  assign consume   = main_valid & out_ready;
  assign out_valid = main_valid;
  // An empty slot never exposes stale payload.
  assign out_data  = main_valid ? main_data : NOP_DATA;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_data  <= NOP_DATA;
      skid_valid <= 1'b0;
      skid_data  <= NOP_DATA;
    end else if (!main_valid) begin
      if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (consume) begin
      // Skid drains first so beats leave in arrival order.
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= NOP_DATA;
      end else if (accept) begin
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= NOP_DATA;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = !main_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_data  <= NOP_DATA;
    end else if (accept) begin
      main_valid <= 1'b1;
      main_data  <= in_data;
    end else if (consume) begin
      main_valid <= 1'b0;
      main_data  <= NOP_DATA;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg
// Honours PIPE_SKID_EN to select the expected in_ready/capacity behaviour.
module tb_pipe_stage_reg;
  localparam int LANE_W = 32;
  localparam int LANES  = 3;
  localparam int CNT_W  = 4;
  localparam int DATA_W = LANE_W * LANES;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.LANE_W(LANE_W), .LANES(LANES), .NOP_VALUE('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity DEPTH; head is what is visible.
  logic [DATA_W-1:0] q[$];
  int  m_cnt = 0;
  bit  started = 0;

  function automatic bit m_in_ready();
`ifdef PIPE_SKID_EN
    return q.size() < DEPTH;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk) begin
    bit acc, con;
    if (reset) begin
      q.delete();
      m_cnt = 0;
      started = 1;
    end else if (started) begin
      acc = in_valid && m_in_ready();
      con = (q.size() > 0) && out_ready;
      if (q.size() == 0 && m_cnt < CNT_MAX) m_cnt++;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("out_data", 128'(out_data), (q.size() > 0) ? 128'(q[0]) : 128'(0));
      chk("in_ready", 128'(in_ready), 128'(m_in_ready()));
      chk("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] beat(input int i);
    logic [LANE_W-1:0] l0, l1, l2;
    l0 = 32'h0040_0000 + 32'(4 * i);
    l1 = 32'h0000_3004 + 32'(4 * i);
    l2 = 32'h0000_3008 + 32'(4 * i);
    return {l2, l1, l0};
  endfunction

  logic [DATA_W-1:0] a_beat, b_beat, c_beat;

  initial begin
    // Reset with a live input beat present.
    reset = 1'b1; in_valid = 1'b1; in_data = {64'h0, 32'hDEAD_BEEF}; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_cnt", 128'(bubble_cnt), 128'(0));
    reset = 1'b0; in_valid = 1'b0;
    tick();

    // Back-to-back streaming.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = beat(i);
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      tick();
      chk("stream_data", 128'(out_data), 128'(beat(i)));
      chk("stream_valid", 128'(out_valid), 128'(1));
    end

    // Stall holding A while B waits upstream.
    a_beat = beat(10); b_beat = beat(11);
    in_data = a_beat;
    tick();
    out_ready = 1'b0; in_data = b_beat;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_a", 128'(out_data), 128'(a_beat));
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    chk("drain_a", 128'(out_data), 128'(a_beat));
    tick();
    chk("drain_b", 128'(out_data), 128'(b_beat));
    in_valid = 1'b0;
    tick();
    chk("drained_empty", 128'(out_valid), 128'(0));

    // Flush in the same cycle as accepting C.
    c_beat = beat(20);
    in_valid = 1'b1; in_data = c_beat; flush = 1'b1;
    tick();
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_data", 128'(out_data), 128'(0));
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_c_gone", 128'(out_valid), 128'(0));

    // Counter saturation after idle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("cnt_sat", 128'(bubble_cnt), 128'(CNT_MAX));

    // Reset while stalled with the stage full.
    out_ready = 1'b1; in_valid = 1'b1; in_data = a_beat;
    tick();
    out_ready = 1'b0; in_data = b_beat;
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    chk("rst_stall_valid", 128'(out_valid), 128'(0));
    chk("rst_stall_ready", 128'(in_ready), 128'(1));
    chk("rst_stall_cnt", 128'(bubble_cnt), 128'(0));
    reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      in_data   = {$urandom, $urandom, $urandom};
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
